key_event_scheduler: RTL and testbench

//  Collects one-cycle press pulses from N_KEYS per-button debouncers and serialises them into one ordered event stream.
//  - Stream format: key index + repeat flag, valid/ready handshake, consumed by game/menu FSM.
//  - Round-robin arbiter shares a single FIFO write port between keys.
//  - One shared auto-repeat timer generates repeat events for the most recently pressed, still-held key.

---
 rtl/key_event_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_key_event_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_scheduler.sv
// rtl/key_event_scheduler.sv - serialises per-key press pulses and auto-repeat ticks into one ordered event stream
module key_event_scheduler #(
    parameter int N_KEYS       = 4,
    parameter int IDX_W        = 2,
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int CNT_W        = 25
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_KEYS-1:0]        key_pulse,
    input  logic [N_KEYS-1:0]        key_held,
    input  logic                     repeat_en,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [IDX_W-1:0]         ev_key,
    output logic                     ev_repeat,
    output logic                     ev_lost,
    input  logic                     clear_lost,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rstate_t;

    // Repeat timer state
    rstate_t            state_q;
    logic [IDX_W-1:0]   rkey_q;
    logic [CNT_W-1:0]   cnt_q;

    // Pending stage and arbiter state
    logic [N_KEYS-1:0]  pend_q, pend_d;
    logic [N_KEYS-1:0]  rep_q, rep_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               ev_lost_q, ev_lost_d;

    // Event FIFO state; head_q is the registered show-ahead output
    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fifo_count_q, fifo_count_d;
    logic [EW-1:0]      head_q, head_d;

    logic               restart;
    logic               abort;
    logic               tick;
    logic [IDX_W-1:0]   press_idx;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   arb_idx;
    logic [N_KEYS-1:0]  grant_vec;
    int                 arb_j;
    logic               lost_set;
    logic               push;
    logic               pop;
    logic [EW-1:0]      push_data;

    assign restart = repeat_en && (|key_pulse);
    assign abort   = !key_held[rkey_q] || !repeat_en;

    // Lowest-indexed key pulsing this cycle becomes the new repeat target
    always_comb begin
        press_idx = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (key_pulse[k]) press_idx = IDX_W'(k);
        end
    end

    // Repeat tick fires on the last count of DELAY/REPEAT unless aborted or restarted
    always_comb begin
        tick = 1'b0;
        if (!restart && !abort) begin
            if (state_q == ST_DELAY && cnt_q == CNT_W'(REPEAT_DELAY - 1)) tick = 1'b1;
            if (state_q == ST_REPEAT && cnt_q == CNT_W'(REPEAT_RATE - 1)) tick = 1'b1;
        end
    end

    // Repeat FSM: a new press always restarts the delay, release or disable aborts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rkey_q  <= '0;
            cnt_q   <= '0;
        end else if (restart) begin
            rkey_q  <= press_idx;
            cnt_q   <= '0;
            state_q <= ST_DELAY;
        end else begin
            case (state_q)
                ST_DELAY: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        state_q <= ST_REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Round-robin pick of the first pending key at or after rr_ptr; grants are
    // judged on the registered count so a same-cycle pop never frees a slot
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        arb_j       = 0;
        arb_idx     = '0;
        if (fifo_count_q < CW'(DEPTH)) begin
            for (int i = N_KEYS - 1; i >= 0; i--) begin
                arb_j = int'(rr_ptr_q) + i;
                if (arb_j >= N_KEYS) arb_j = arb_j - N_KEYS;
                arb_idx = IDX_W'(arb_j);
                if (pend_q[arb_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = arb_idx;
                end
            end
        end
        if (grant_valid) grant_vec[grant_idx] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == IDX_W'(N_KEYS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Pending bits: a new set beats a same-cycle grant; presses override repeats
    always_comb begin
        pend_d   = pend_q;
        rep_d    = rep_q;
        lost_set = 1'b0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (key_pulse[k]) begin
                if (pend_q[k] && !grant_vec[k]) lost_set = 1'b1;
                pend_d[k] = 1'b1;
                rep_d[k]  = 1'b0;
            end else if (tick && rkey_q == IDX_W'(k)) begin
                if (!pend_q[k] || grant_vec[k]) rep_d[k] = 1'b1;
                pend_d[k] = 1'b1;
            end else if (grant_vec[k]) begin
                pend_d[k] = 1'b0;
            end
        end
        ev_lost_d = lost_set ? 1'b1 : (clear_lost ? 1'b0 : ev_lost_q);
    end

    assign push      = grant_valid;
    assign push_data = {grant_idx, rep_q[grant_idx]};
    assign pop       = (fifo_count_q != '0) && ev_ready;

    // FIFO pointers, occupancy and next head; the head holds its value when the FIFO drains
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
        head_d = head_q;
        if (fifo_count_d != '0) begin
            head_d = (push && rd_ptr_d == wr_ptr_q) ? push_data : mem_q[rd_ptr_d];
        end
    end

    // FIFO storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Pending, arbiter and FIFO control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= '0;
            rep_q        <= '0;
            rr_ptr_q     <= '0;
            ev_lost_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            head_q       <= '0;
        end else begin
            pend_q       <= pend_d;
            rep_q        <= rep_d;
            rr_ptr_q     <= rr_ptr_d;
            ev_lost_q    <= ev_lost_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            head_q       <= head_d;
        end
    end

    assign ev_valid   = (fifo_count_q != '0);
    assign ev_key     = head_q[EW-1:1];
    assign ev_repeat  = head_q[0];
    assign ev_lost    = ev_lost_q;
    assign fifo_count = fifo_count_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb/tb_key_event_scheduler.sv - randomized scoreboard bench for key_event_scheduler
module tb_key_event_scheduler;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 4;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [N-1:0] key_pulse  = '0;
    logic [N-1:0] key_held   = '0;
    logic         repeat_en  = 1'b0;
    logic         ev_ready   = 1'b0;
    logic         clear_lost = 1'b0;
    logic         ev_valid;
    logic [1:0]   ev_key;
    logic         ev_repeat;
    logic         ev_lost;
    logic [2:0]   fifo_count;

    key_event_scheduler #(
        .N_KEYS(N), .IDX_W(2), .DEPTH(D),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .key_pulse(key_pulse), .key_held(key_held), .repeat_en(repeat_en),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
        .ev_repeat(ev_repeat), .ev_lost(ev_lost), .clear_lost(clear_lost),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model state: expected events are key*2+repeat, in stream order
    int           sb[$];
    int           flush_mark = 0;
    int           m_count = 0;
    bit           m_lost = 1'b0;
    bit           done = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: timer as an absolute "next tick" cycle, FIFO as a plain count
    initial begin : model
        int     cyc, rr, g, low, tk, t_key, t_next;
        bit     t_active, tick, pop, still, lset;
        bit     pend[N];
        bit     rep[N];
        cyc = 0; rr = 0; t_active = 0; t_key = 0; t_next = 0;
        for (int k = 0; k < N; k++) begin pend[k] = 0; rep[k] = 0; end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int k = 0; k < N; k++) begin pend[k] = 0; rep[k] = 0; end
                rr = 0; m_count = 0; m_lost = 0; t_active = 0;
                flush_mark = sb.size();
            end else begin
                tick = 0; tk = 0;
                if (repeat_en && key_pulse != '0) begin
                    low = 0;
                    for (int k = N - 1; k >= 0; k--) if (key_pulse[k]) low = k;
                    t_active = 1; t_key = low; t_next = cyc + RD;
                end else if (t_active) begin
                    if (!key_held[t_key] || !repeat_en) t_active = 0;
                    else if (cyc == t_next) begin
                        tick = 1; tk = t_key; t_next = cyc + RR;
                    end
                end
                g = -1;
                if (m_count < D)
                    for (int i = 0; i < N; i++)
                        if (g < 0 && pend[(rr + i) % N]) g = (rr + i) % N;
                pop = (m_count > 0) && ev_ready;
                if (g >= 0) begin
                    sb.push_back(g * 2 + int'(rep[g]));
                    rr = (g + 1) % N;
                end
                m_count = m_count + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
                lset = 0;
                for (int k = 0; k < N; k++) begin
                    still = pend[k] && (g != k);
                    if (key_pulse[k]) begin
                        if (still) lset = 1;
                        pend[k] = 1; rep[k] = 0;
                    end else if (tick && tk == k) begin
                        if (!still) rep[k] = 1;
                        pend[k] = 1;
                    end else if (g == k) begin
                        pend[k] = 0;
                    end
                end
                if (lset) m_lost = 1;
                else if (clear_lost) m_lost = 0;
                cyc++;
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle and consumes the scoreboard on pops
    initial begin : monitor
        int rd_idx, last;
        bit drained;
        rd_idx = 0; last = 0; drained = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_idx = flush_mark;
                last = 0;
            end
            chk("fifo_count", int'(fifo_count), m_count);
            chk("ev_valid", int'(ev_valid), (m_count != 0) ? 1 : 0);
            chk("ev_lost", int'(ev_lost), int'(m_lost));
            if (ev_valid) begin
                if (rd_idx < sb.size()) begin
                    chk("head_event", int'({ev_key, ev_repeat}), sb[rd_idx]);
                    if (ev_ready) begin
                        last = sb[rd_idx];
                        rd_idx++;
                    end
                end else begin
                    chk("head_expected", sb.size(), rd_idx + 1);
                end
            end else begin
                chk("idle_head", int'({ev_key, ev_repeat}), last);
            end
            if (done && !drained) begin
                chk("drained", sb.size() - rd_idx, 0);
                drained = 1;
            end
        end
    end

    task automatic drive(input logic [N-1:0] kp, input logic [N-1:0] kh,
                         input logic en, input logic rdy, input logic clr);
        key_pulse  = kp;
        key_held   = kh;
        repeat_en  = en;
        ev_ready   = rdy;
        clear_lost = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        logic [N-1:0] held, kp;
        logic         en, rdy, clr;
        int           rmode;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;

        // single press, consumer ready
        drive(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (5) drive('0, '0, 1'b0, 1'b1, 1'b0);

        // simultaneous presses, then round-robin after wrap
        drive(4'b1011, '0, 1'b0, 1'b0, 1'b0);
        repeat (5) drive('0, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b1001, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (10) drive('0, '0, 1'b0, 1'b1, 1'b0);

        // saturate FIFO, hold pending, lost press, clear, drain
        drive(4'b1111, '0, 1'b0, 1'b0, 1'b0);
        repeat (5) drive('0, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b0011, '0, 1'b0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        drive(4'b0001, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) drive('0, '0, 1'b0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        repeat (12) drive('0, '0, 1'b0, 1'b1, 1'b0);

        // hold key 1 with auto-repeat, then release
        drive(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
        repeat (20) drive('0, 4'b0010, 1'b1, 1'b1, 1'b0);
        repeat (10) drive('0, '0, 1'b1, 1'b1, 1'b0);

        // key 2 steals the repeat target, then repeat disabled
        drive(4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
        repeat (13) drive('0, 4'b0010, 1'b1, 1'b1, 1'b0);
        drive(4'b0100, 4'b0110, 1'b1, 1'b1, 1'b0);
        repeat (14) drive('0, 4'b0110, 1'b1, 1'b1, 1'b0);
        repeat (10) drive('0, 4'b0110, 1'b0, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b1, 1'b0);

        // reset with events queued and timer repeating
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (14) drive('0, 4'b0010, 1'b1, 1'b0, 1'b0);
        drive(4'b1001, 4'b1011, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 4'b1011, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (3) drive('0, '0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (10) drive('0, '0, 1'b1, 1'b1, 1'b0);

        // randomized traffic with varying consumer behaviour and a mid-run reset
        held = '0; en = 1'b1; rmode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) rmode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 199) == 0) en = ~en;
            kp = '0;
            for (int k = 0; k < N; k++) begin
                if (!held[k]) begin
                    if ($urandom_range(0, 15) == 0) begin kp[k] = 1'b1; held[k] = 1'b1; end
                end else if ($urandom_range(0, 29) == 0) begin
                    held[k] = 1'b0;
                end else if ($urandom_range(0, 63) == 0) begin
                    kp[k] = 1'b1;
                end
            end
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            clr = ($urandom_range(0, 15) == 0);
            if (n == 1500) reset_n = 1'b0;
            if (n == 1503) reset_n = 1'b1;
            drive(kp, held, en, rdy, clr);
        end

        repeat (20) drive('0, '0, 1'b0, 1'b1, 1'b0);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
